// File: rtl/sad_pkg.sv
// Shared definitions for the SAD buffer decode and responder logic:
// fill-state encodings, default geometry and the buffer-related opcodes.
package sad_pkg;

  localparam int SAD_ROWS_DEFAULT = 4;

  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_PARTIAL = 2'd1,
    FILL_FULL    = 2'd2,
    FILL_UNUSED  = 2'd3
  } fill_state_e;

  // Opcodes shared with the ID-stage decoder
  localparam logic [5:0] SAD_A = 6'h2A;
  localparam logic [5:0] SAD_B = 6'h2B;
  localparam logic [5:0] LBUFA = 6'h2C;
  localparam logic [5:0] LBUFB = 6'h2D;

endpackage

// File: rtl/sad_row_buffer.sv
// One ROWS x 32-bit buffer with per-row valid flags.
// Handles load, shift-up and clear, with priority clear > shift > load.
module sad_row_buffer
  import sad_pkg::*;
#(
  parameter int ROWS  = SAD_ROWS_DEFAULT,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clear,
  input  logic [IDX_W-1:0]     row_idx,
  input  logic [31:0]          wr_data,
  output logic [32*ROWS-1:0]   data_flat,
  output logic [ROWS-1:0]      valid_next
);

  logic [ROWS-1:0][31:0] data_q, data_d;
  logic [ROWS-1:0]       valid_q, valid_upd;

  // Data write and flag update; a colliding load is dropped in favour of the shift
  always_comb begin
    data_d    = data_q;
    valid_upd = valid_q;
    if (shift) begin
      for (int r = 0; r < ROWS - 1; r++) begin
        data_d[r]    = data_q[r+1];
        valid_upd[r] = valid_q[r+1];
      end
      data_d[ROWS-1]    = wr_data;
      valid_upd[ROWS-1] = 1'b1;
    end else if (load) begin
      data_d[row_idx]    = wr_data;
      valid_upd[row_idx] = 1'b1;
    end else begin
      data_d    = data_q;
      valid_upd = valid_q;
    end
  end

  // Clear only drops the flags; the data write above still lands
  always_comb begin
    valid_next = valid_upd;
    if (clear) begin
      valid_next = '0;
    end else begin
      valid_next = valid_upd;
    end
  end

  // Buffer storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_next;
    end
  end

  assign data_flat = data_q;

endmodule

// File: rtl/sad_buffer_filler.sv
// SAD buffer responder: two row buffers, fill FSM, all-valid flag and protocol error.
// Optional macro SAD_BUF_FILL_CNT_EN adds the fill_cycles PARTIAL-time counter.
module sad_buffer_filler
  import sad_pkg::*;
#(
  parameter int ROWS  = SAD_ROWS_DEFAULT,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               load_buff_a,
  input  logic               load_buff_b,
  input  logic               window_shift,
  input  logic               frame_shift,
  input  logic [IDX_W-1:0]   row_idx,
  input  logic [31:0]        mem_data,
  input  logic               buf_clear,
  output logic               all_buf_flags,
  output logic [32*ROWS-1:0] buf_a,
  output logic [32*ROWS-1:0] buf_b,
  output logic [1:0]         state,
  output logic               proto_err
`ifdef SAD_BUF_FILL_CNT_EN
  ,
  output logic [15:0]        fill_cycles
`endif
);

  logic [ROWS-1:0] valid_a_next, valid_b_next;
  fill_state_e     state_q, state_d;
  logic            all_flags_q, all_flags_d;
  logic            proto_err_q, proto_err_d;
  logic            flags_all_s, flags_any_s;

  sad_row_buffer #(.ROWS(ROWS), .IDX_W(IDX_W)) u_buf_a (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .load       (load_buff_a),
    .shift      (window_shift),
    .clear      (buf_clear),
    .row_idx    (row_idx),
    .wr_data    (mem_data),
    .data_flat  (buf_a),
    .valid_next (valid_a_next)
  );

  sad_row_buffer #(.ROWS(ROWS), .IDX_W(IDX_W)) u_buf_b (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .load       (load_buff_b),
    .shift      (frame_shift),
    .clear      (buf_clear),
    .row_idx    (row_idx),
    .wr_data    (mem_data),
    .data_flat  (buf_b),
    .valid_next (valid_b_next)
  );

  // Fill FSM, all-valid flag and sticky protocol error, all from next-state flags
  always_comb begin
    flags_all_s = (&valid_a_next) & (&valid_b_next);
    flags_any_s = (|valid_a_next) | (|valid_b_next);
    all_flags_d = flags_all_s;
    proto_err_d = proto_err_q | (load_buff_a & window_shift) | (load_buff_b & frame_shift);
    state_d     = FILL_EMPTY;
    case (state_q)
      FILL_EMPTY, FILL_PARTIAL, FILL_FULL: begin
        if (buf_clear) begin
          state_d = FILL_EMPTY;
        end else if (flags_all_s) begin
          state_d = FILL_FULL;
        end else if (flags_any_s) begin
          state_d = FILL_PARTIAL;
        end else begin
          state_d = FILL_EMPTY;
        end
      end
      default: state_d = FILL_EMPTY;
    endcase
  end

  // Control registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= FILL_EMPTY;
      all_flags_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      all_flags_q <= all_flags_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign state         = state_q;
  assign all_buf_flags = all_flags_q;
  assign proto_err     = proto_err_q;

`ifdef SAD_BUF_FILL_CNT_EN
  logic [15:0] fill_cycles_q, fill_cycles_d;

  // Saturating PARTIAL-time counter, restarted on each EMPTY to PARTIAL entry
  always_comb begin
    fill_cycles_d = fill_cycles_q;
    if ((state_q == FILL_EMPTY) && (state_d == FILL_PARTIAL)) begin
      fill_cycles_d = 16'd0;
    end else if ((state_q == FILL_PARTIAL) && (fill_cycles_q != 16'hFFFF)) begin
      fill_cycles_d = fill_cycles_q + 16'd1;
    end else begin
      fill_cycles_d = fill_cycles_q;
    end
  end

  // Counter register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fill_cycles_q <= 16'd0;
    end else begin
      fill_cycles_q <= fill_cycles_d;
    end
  end

  assign fill_cycles = fill_cycles_q;
`endif

endmodule

// File: tb/tb_sad_buffer_filler.sv
// Scoreboard bench for sad_buffer_filler (ROWS=4): expected outputs are pushed
// when a request is driven and compared one cycle later.
module tb_sad_buffer_filler;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         load_buff_a = 1'b0, load_buff_b = 1'b0;
  logic         window_shift = 1'b0, frame_shift = 1'b0, buf_clear = 1'b0;
  logic [1:0]   row_idx = 2'd0;
  logic [31:0]  mem_data = 32'd0;
  logic         all_buf_flags, proto_err;
  logic [127:0] buf_a, buf_b;
  logic [1:0]   state;
`ifdef SAD_BUF_FILL_CNT_EN
  logic [15:0]  fill_cycles;
`endif

  sad_buffer_filler #(.ROWS(4)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .load_buff_a   (load_buff_a),
    .load_buff_b   (load_buff_b),
    .window_shift  (window_shift),
    .frame_shift   (frame_shift),
    .row_idx       (row_idx),
    .mem_data      (mem_data),
    .buf_clear     (buf_clear),
    .all_buf_flags (all_buf_flags),
    .buf_a         (buf_a),
    .buf_b         (buf_b),
    .state         (state),
    .proto_err     (proto_err)
`ifdef SAD_BUF_FILL_CNT_EN
    ,
    .fill_cycles   (fill_cycles)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         all;
    logic [1:0]   st;
    logic         pe;
    logic [127:0] a;
    logic [127:0] b;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [127:0] m_a, m_b;
  logic [3:0]   m_va, m_vb;
  logic         m_pe;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_va = 4'd0; m_vb = 4'd0; m_pe = 1'b0;
  endtask

  task automatic upd_buf(input logic [127:0] din, input logic [3:0] vin,
                         input logic ld, input logic sh, input logic cl,
                         input logic [1:0] ix, input logic [31:0] d,
                         output logic [127:0] dout, output logic [3:0] vout);
    dout = din;
    vout = vin;
    if (sh) begin
      dout = {d, din[127:32]};
      vout = {1'b1, vin[3:1]};
    end else if (ld) begin
      dout[ix*32 +: 32] = d;
      vout[ix] = 1'b1;
    end
    if (cl) vout = 4'd0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_all"}, {127'd0, all_buf_flags}, 128'd0);
    check_eq({tag, "_state"}, {126'd0, state}, 128'd0);
    check_eq({tag, "_perr"}, {127'd0, proto_err}, 128'd0);
    check_eq({tag, "_buf_a"}, buf_a, 128'd0);
    check_eq({tag, "_buf_b"}, buf_b, 128'd0);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 128'd1, 128'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("all_buf_flags", {127'd0, all_buf_flags}, {127'd0, e.all});
      check_eq("state", {126'd0, state}, {126'd0, e.st});
      check_eq("proto_err", {127'd0, proto_err}, {127'd0, e.pe});
      check_eq("buf_a", buf_a, e.a);
      check_eq("buf_b", buf_b, e.b);
    end
  endtask

  task automatic step(input logic la, input logic lb, input logic ws, input logic fs,
                      input logic cl, input logic [1:0] ix, input logic [31:0] d);
    exp_t e;
    @(negedge Clk);
    load_buff_a = la; load_buff_b = lb; window_shift = ws; frame_shift = fs;
    buf_clear = cl; row_idx = ix; mem_data = d;
    upd_buf(m_a, m_va, la, ws, cl, ix, d, m_a, m_va);
    upd_buf(m_b, m_vb, lb, fs, cl, ix, d, m_b, m_vb);
    m_pe = m_pe | (la & ws) | (lb & fs);
    e.all = (&m_va) & (&m_vb);
    e.st  = cl ? 2'd0 : (e.all ? 2'd2 : ((|m_va) || (|m_vb)) ? 2'd1 : 2'd0);
    e.pe  = m_pe;
    e.a   = m_a;
    e.b   = m_b;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    compare_out();
    load_buff_a = 1'b0; load_buff_b = 1'b0; window_shift = 1'b0;
    frame_shift = 1'b0; buf_clear = 1'b0;
  endtask

  task automatic apply_reset();
    Rst_n = 1'b0;
    load_buff_a = 1'b0; load_buff_b = 1'b0; window_shift = 1'b0;
    frame_shift = 1'b0; buf_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_zero("reset");
    Rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Fill A by row loads; B still empty
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(i), 32'h11111111 * 32'(i + 1));
    check_eq("a_only_state", {126'd0, state}, 128'd1);

    // Fill B in reverse order; flag rises right after the last load
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(3 - i), 32'hB0000000 + 32'(i));
    check_eq("full_all", {127'd0, all_buf_flags}, 128'd1);
    check_eq("full_state", {126'd0, state}, 128'd2);
    check_eq("b_row3_first", {96'd0, buf_b[127:96]}, {96'd0, 32'hB0000000});

    // Shift A while full
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hAABBCCDD);
    check_eq("wshift_rows", buf_a, {32'hAABBCCDD, 32'h44444444, 32'h33333333, 32'h22222222});
    check_eq("wshift_all", {127'd0, all_buf_flags}, 128'd1);

    // Shift-fill B from empty, then an illegal A load+shift
    apply_reset();
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'(i), 32'hD0D0D000 + 32'(i));
    check_eq("fshift_rows", buf_b, {32'hD0D0D003, 32'hD0D0D002, 32'hD0D0D001, 32'hD0D0D000});
    check_eq("fshift_all", {127'd0, all_buf_flags}, 128'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'hE1E1E1E1);
    check_eq("illegal_perr", {127'd0, proto_err}, 128'd1);
    check_eq("illegal_a_row1", {96'd0, buf_a[63:32]}, 128'd0);

    // Complete A by shifts, then clear together with a B load
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hC0000000 + 32'(i));
    check_eq("refill_state", {126'd0, state}, 128'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h12345678);
    check_eq("clr_all", {127'd0, all_buf_flags}, 128'd0);
    check_eq("clr_state", {126'd0, state}, 128'd0);
    check_eq("clr_b_row2", {96'd0, buf_b[95:64]}, {96'd0, 32'h12345678});
    check_eq("clr_perr_sticky", {127'd0, proto_err}, 128'd1);

    // Asynchronous reset between clock edges in the middle of a fill
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h5A5A5A5A);
    @(negedge Clk);
    load_buff_a = 1'b1; row_idx = 2'd1; mem_data = 32'h6B6B6B6B;
    #2 Rst_n = 1'b0;
    #1 check_zero("async_rst");
    load_buff_a = 1'b0;
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h77777777);
`ifdef SAD_BUF_FILL_CNT_EN
    check_eq("fill_cnt_restart", {112'd0, fill_cycles}, 128'd0);
`endif

    check_eq("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
